// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store request stage: funct3 values,
// access-size codes and the stage FSM state type.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // funct3[1:0] selects the access size for both loads and stores
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HELD
    } state_t;

endpackage

// File: rtl/lsu_mask_gen.sv
// Byte-enable generation for one access split across the addressed word and
// the following word; size code 11 has no valid encoding.
module lsu_mask_gen
    import lsu_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_offset,
    output logic [3:0] o_align,
    output logic [3:0] o_misalign,
    output logic       o_size_illegal
);

    always_comb begin
        o_align        = 4'b0000;
        o_misalign     = 4'b0000;
        o_size_illegal = (i_size == 2'b11);
        case (i_size)
            SZ_BYTE: o_align = 4'b0001 << i_offset;
            SZ_HALF: begin
                case (i_offset)
                    2'd0: o_align = 4'b0011;
                    2'd1: o_align = 4'b0110;
                    2'd2: o_align = 4'b1100;
                    2'd3: begin
                        o_align    = 4'b1000;
                        o_misalign = 4'b0001;
                    end
                endcase
            end
            SZ_WORD: begin
                case (i_offset)
                    2'd0: o_align = 4'b1111;
                    2'd1: begin
                        o_align    = 4'b1110;
                        o_misalign = 4'b0001;
                    end
                    2'd2: begin
                        o_align    = 4'b1100;
                        o_misalign = 4'b0011;
                    end
                    2'd3: begin
                        o_align    = 4'b1000;
                        o_misalign = 4'b0111;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_req_stage.sv
// EX/MEM request register: captures load/store requests, drives one-shot
// memory enables, flags illegal accesses and tags load data for writeback.
//
// state   | meaning
// S_IDLE  | no request held, enables low
// S_ISSUE | request presented this cycle, enables/fault pulse active
// S_HELD  | memory stalled, request held with enables low
module lsu_req_stage
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int MEM_WORDS      = 4096,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_is_load,
    input  logic              i_is_store,
    input  logic [2:0]        i_func3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [4:0]        i_rd,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [ADDR_W-1:0] o_addr,
    output logic [2:0]        o_func3,
    output logic [31:0]       o_wdata,
    output logic [3:0]        o_bmask_align,
    output logic [3:0]        o_bmask_misalign,
    output logic              o_wren,
    output logic              o_rden,
    output logic              o_ld_valid,
    output logic [4:0]        o_ld_rd,
    output logic              o_fault,
    output logic [31:0]       o_fault_addr
);

    localparam logic [11:0] TOP_WORD = 12'(MEM_WORDS - 1);

    state_t     state;
    logic [4:0] req_rd;
    logic [3:0] mask_a;
    logic [3:0] mask_m;
    logic       size_illegal;
    logic       capture;
    logic       bad_func3;
    logic       illegal;
    logic       ld_pending;

    lsu_mask_gen u_mask_gen (
        .i_size         (i_func3[1:0]),
        .i_offset       (i_addr[1:0]),
        .o_align        (mask_a),
        .o_misalign     (mask_m),
        .o_size_illegal (size_illegal)
    );

    always_comb begin
        capture   = i_valid & (i_is_load | i_is_store) & ~i_stall & ~i_flush;
        bad_func3 = (i_is_load  & !(i_func3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}))
                  | (i_is_store & !(i_func3 inside {F3_SB, F3_SH, F3_SW}));
        // a spill into the word past the top of memory would wrap to word 0
        illegal   = size_illegal | bad_func3 | (i_is_load & i_is_store)
                  | ((|mask_m) & (!ALLOW_MISALIGN || (i_addr[13:2] == TOP_WORD)));
        // o_rden is only ever high in S_ISSUE, so it marks a legal load issuing now
        ld_pending = o_rden & ~i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state            <= S_IDLE;
            req_rd           <= '0;
            o_addr           <= '0;
            o_func3          <= '0;
            o_wdata          <= '0;
            o_bmask_align    <= '0;
            o_bmask_misalign <= '0;
            o_wren           <= 1'b0;
            o_rden           <= 1'b0;
            o_ld_valid       <= 1'b0;
            o_ld_rd          <= '0;
            o_fault          <= 1'b0;
            o_fault_addr     <= '0;
        end else begin
            o_wren     <= 1'b0;
            o_rden     <= 1'b0;
            o_fault    <= 1'b0;
            o_ld_valid <= ld_pending;
            o_ld_rd    <= ld_pending ? req_rd : 5'd0;
            if (i_flush) begin
                state <= S_IDLE;
            end else if (i_stall) begin
                if (state != S_IDLE) state <= S_HELD;
            end else if (capture) begin
                state            <= S_ISSUE;
                req_rd           <= i_rd;
                o_addr           <= i_addr[ADDR_W-1:0];
                o_func3          <= i_func3;
                o_wdata          <= i_wdata;
                o_bmask_align    <= mask_a;
                o_bmask_misalign <= mask_m;
                o_wren           <= i_is_store & ~illegal;
                o_rden           <= i_is_load & ~illegal;
                o_fault          <= illegal;
                if (illegal) o_fault_addr <= i_addr;
            end else begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_lsu_req_stage.sv
// Self-checking bench for lsu_req_stage: vector table streamed back-to-back
// through a due-cycle scoreboard, plus stall, flush and reset sequences.
module tb_lsu_req_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid, i_is_load, i_is_store, i_stall, i_flush;
    logic [2:0]  i_func3;
    logic [31:0] i_addr, i_wdata;
    logic [4:0]  i_rd;
    logic [15:0] o_addr;
    logic [2:0]  o_func3;
    logic [31:0] o_wdata;
    logic [3:0]  o_bmask_align, o_bmask_misalign;
    logic        o_wren, o_rden, o_ld_valid, o_fault;
    logic [4:0]  o_ld_rd;
    logic [31:0] o_fault_addr;

    lsu_req_stage dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_is_load(i_is_load),
        .i_is_store(i_is_store), .i_func3(i_func3), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rd(i_rd), .i_stall(i_stall), .i_flush(i_flush), .o_addr(o_addr),
        .o_func3(o_func3), .o_wdata(o_wdata), .o_bmask_align(o_bmask_align),
        .o_bmask_misalign(o_bmask_misalign), .o_wren(o_wren), .o_rden(o_rden),
        .o_ld_valid(o_ld_valid), .o_ld_rd(o_ld_rd), .o_fault(o_fault),
        .o_fault_addr(o_fault_addr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  ea;
        logic [3:0]  em;
        bit          efault;
        bit          chkm;
    } vec_t;

    typedef struct { int due; vec_t v; } iss_t;
    typedef struct { int due; logic [4:0] rd; } ldexp_t;

    iss_t   iss_q[$];
    ldexp_t ld_q[$];
    vec_t   tbl[$];
    vec_t   idle_v;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 0;
    bit     pend_ld = 0;
    logic [4:0] pend_rd;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [3:0] ea,
                                input logic [3:0] em, input bit efault, input bit chkm);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.ea = ea; v.em = em; v.efault = efault; v.chkm = chkm;
        return v;
    endfunction

    // one call per cycle: applies inputs at the negedge and books expectations
    task automatic drive(input vec_t v, input bit valid, input bit stall,
                         input bit flush, input bit rstn);
        iss_t   ie;
        ldexp_t le;
        @(negedge i_clk);
        if (pend_ld && !flush && rstn) begin
            le.due = cyc + 1; le.rd = pend_rd;
            ld_q.push_back(le);
        end
        pend_ld = 0;
        i_reset = rstn; i_valid = valid; i_is_load = v.ld; i_is_store = v.st;
        i_func3 = v.f3; i_addr = v.addr; i_wdata = v.wdata; i_rd = v.rd;
        i_stall = stall; i_flush = flush;
        if (rstn && valid && (v.ld || v.st) && !stall && !flush) begin
            ie.due = cyc + 1; ie.v = v;
            iss_q.push_back(ie);
            pend_ld = v.ld && !v.efault;
            pend_rd = v.rd;
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            while (iss_q.size() > 0 && iss_q[0].due < cyc) begin
                chk("iss_stale", cyc, iss_q[0].due);
                void'(iss_q.pop_front());
            end
            while (ld_q.size() > 0 && ld_q[0].due < cyc) begin
                chk("ld_stale", cyc, ld_q[0].due);
                void'(ld_q.pop_front());
            end
            if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
                iss_t e;
                e = iss_q.pop_front();
                chk("wren",  o_wren,  e.v.st & !e.v.efault);
                chk("rden",  o_rden,  e.v.ld & !e.v.efault);
                chk("fault", o_fault, e.v.efault);
                chk("addr",  o_addr,  e.v.addr[15:0]);
                chk("func3", o_func3, e.v.f3);
                chk("wdata", o_wdata, e.v.wdata);
                if (e.v.chkm) begin
                    chk("mask_align",    o_bmask_align,    e.v.ea);
                    chk("mask_misalign", o_bmask_misalign, e.v.em);
                end
                if (e.v.efault) chk("fault_addr", o_fault_addr, e.v.addr);
            end else begin
                chk("idle_wren",  o_wren,  1'b0);
                chk("idle_rden",  o_rden,  1'b0);
                chk("idle_fault", o_fault, 1'b0);
            end
            if (ld_q.size() > 0 && ld_q[0].due == cyc) begin
                ldexp_t l;
                l = ld_q.pop_front();
                chk("ld_valid", o_ld_valid, 1'b1);
                chk("ld_rd",    o_ld_rd,    l.rd);
            end else begin
                chk("no_ld_valid", o_ld_valid, 1'b0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},  o_addr, 0);
        chk({tag, "_func3"}, o_func3, 0);
        chk({tag, "_wdata"}, o_wdata, 0);
        chk({tag, "_ma"},    o_bmask_align, 0);
        chk({tag, "_mm"},    o_bmask_misalign, 0);
        chk({tag, "_wren"},  o_wren, 0);
        chk({tag, "_rden"},  o_rden, 0);
        chk({tag, "_ldv"},   o_ld_valid, 0);
        chk({tag, "_ldrd"},  o_ld_rd, 0);
        chk({tag, "_flt"},   o_fault, 0);
        chk({tag, "_fa"},    o_fault_addr, 0);
    endtask

    initial begin
        vec_t sv, l3, l4, l9;
        idle_v = mk(0, 0, 3'b000, 32'h0, 32'h0, 5'd0, 4'b0, 4'b0, 0, 0);
        //         ld st f3      addr          wdata         rd     align    misalign fault chkm
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 5'd0,  4'b1100, 4'b0011, 0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 32'h0000_0013, 32'h0,         5'd7,  4'b1000, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 32'h0000_0021, 32'h0,         5'd1,  4'b0010, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b100, 32'h0000_0007, 32'h0,         5'd2,  4'b1000, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b101, 32'h0000_0002, 32'h0,         5'd5,  4'b1100, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0040, 32'h0,         5'd6,  4'b1111, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0041, 32'h0,         5'd8,  4'b1110, 4'b0001, 0, 1));
        tbl.push_back(mk(0, 1, 3'b001, 32'h0000_0001, 32'h1234_5678, 5'd0,  4'b0110, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 3'b000, 32'h0000_0003, 32'h0000_00EE, 5'd0,  4'b1000, 4'b0000, 0, 1));
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_3FFD, 32'hDEAD_BEEF, 5'd0,  4'b1110, 4'b0001, 1, 1));
        tbl.push_back(mk(0, 1, 3'b100, 32'h0000_0010, 32'h5555_5555, 5'd0,  4'b0001, 4'b0000, 1, 1));
        tbl.push_back(mk(1, 0, 3'b011, 32'h0000_0020, 32'h0,         5'd12, 4'b0000, 4'b0000, 1, 0));
        tbl.push_back(mk(1, 1, 3'b010, 32'h0000_0008, 32'h0,         5'd13, 4'b1111, 4'b0000, 1, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_3FFC, 32'h0,         5'd10, 4'b1111, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 32'h0000_3FFE, 32'h0,         5'd14, 4'b1100, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b001, 32'h0000_3FFF, 32'h0,         5'd15, 4'b1000, 4'b0001, 1, 1));
        tbl.push_back(mk(1, 0, 3'b110, 32'h0000_0050, 32'h0,         5'd16, 4'b1111, 4'b0000, 1, 1));
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_7FFD, 32'h0F0F_0F0F, 5'd0,  4'b1110, 4'b0001, 1, 1));
        tbl.push_back(mk(0, 1, 3'b010, 32'h0000_4001, 32'hCAFE_F00D, 5'd0,  4'b1110, 4'b0001, 0, 1));
        tbl.push_back(mk(1, 0, 3'b000, 32'h1234_0102, 32'h0,         5'd11, 4'b0100, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b010, 32'h0000_0100, 32'h0,         5'd17, 4'b1111, 4'b0000, 0, 1));
        tbl.push_back(mk(1, 0, 3'b101, 32'h0000_0103, 32'h0,         5'd18, 4'b1000, 4'b0001, 0, 1));

        i_reset = 0; i_valid = 0; i_is_load = 0; i_is_store = 0; i_func3 = 0;
        i_addr = 0; i_wdata = 0; i_rd = 0; i_stall = 0; i_flush = 0;
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        mon_en = 1;

        // back-to-back stream, including consecutive loads
        foreach (tbl[k]) drive(tbl[k], 1, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);

        // store then 3 stall cycles: one write, request held, capture on release
        sv = mk(0, 1, 3'b001, 32'h0000_0205, 32'h1122_3344, 5'd0, 4'b0110, 4'b0000, 0, 1);
        drive(sv, 1, 0, 0, 1);
        drive(tbl[1], 1, 1, 0, 1);
        drive(tbl[1], 1, 1, 0, 1);
        chk("held_addr", o_addr, 16'h0205);
        chk("held_ma", o_bmask_align, 4'b0110);
        chk("held_wdata", o_wdata, 32'h1122_3344);
        drive(tbl[1], 1, 1, 0, 1);
        chk("held2_addr", o_addr, 16'h0205);
        chk("held2_ma", o_bmask_align, 4'b0110);
        drive(tbl[1], 1, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);

        // flush in the load's issue cycle kills its response; next load is normal
        l3 = mk(1, 0, 3'b010, 32'h0000_0060, 32'h0, 5'd3, 4'b1111, 4'b0000, 0, 1);
        l4 = mk(1, 0, 3'b010, 32'h0000_0064, 32'h0, 5'd4, 4'b1111, 4'b0000, 0, 1);
        drive(l3, 1, 0, 0, 1);
        drive(idle_v, 0, 0, 1, 1);
        drive(l4, 1, 0, 1, 1);
        drive(l4, 1, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);

        // reset while held, then reset in a load's issue cycle
        l9 = mk(1, 0, 3'b010, 32'h0000_0080, 32'h0, 5'd9, 4'b1111, 4'b0000, 0, 1);
        drive(l9, 1, 0, 0, 1);
        drive(idle_v, 0, 1, 0, 1);
        drive(idle_v, 0, 1, 0, 0);
        drive(idle_v, 0, 0, 0, 1);
        chk_all_zero("rst_held");
        drive(l9, 1, 0, 0, 1);
        drive(idle_v, 0, 1, 0, 0);
        drive(idle_v, 0, 0, 0, 1);
        chk_all_zero("rst_issue");
        drive(l4, 1, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);
        drive(idle_v, 0, 0, 0, 1);

        chk("iss_q_left", iss_q.size(), 0);
        chk("ld_q_left", ld_q.size(), 0);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_req_stage.md
Name: lsu_req_stage

Overview:
- EX/MEM boundary stage that sits directly upstream of the data memory.
- Registers each load/store request coming from execute.
- Derives the 16-bit memory address, aligned and misaligned byte masks, and one-shot write/read enables, and checks the access for legality.
- Tags the registered memory read data with the destination register one cycle later, so writeback can consume it.

Parameters:
- ADDR_W, 16, width of the address presented to the memory.
- MEM_WORDS, 4096, number of 32-bit words in the data memory; the top word index is MEM_WORDS-1.
- ALLOW_MISALIGN, 1, 1 = accesses that cross a word boundary use the misaligned mask; 0 = any misaligned access faults.

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_reset  in  1  synchronous, active-low reset (reset when i_reset==0).
- i_valid  in  1  execute presents a request this cycle.
- i_is_load  in  1  request is a load.
- i_is_store  in  1  request is a store.
- i_func3  in  3  RISC-V funct3 of the load/store.
- i_addr  in  32  effective byte address.
- i_wdata  in  32  store data.
- i_rd  in  5  load destination register.
- i_stall  in  1  memory stage must hold its current request.
- i_flush  in  1  kill the captured request and any pending load response.
- o_addr  out  ADDR_W  byte address to memory (i_addr[ADDR_W-1:0]).
- o_func3  out  3  funct3 to memory.
- o_wdata  out  32  store data to memory.
- o_bmask_align  out  4  byte enables for word addr[13:2].
- o_bmask_misalign  out  4  byte enables for word addr[13:2]+1.
- o_wren  out  1  store enable, one cycle per request.
- o_rden  out  1  load enable, one cycle per request.
- o_ld_valid  out  1  memory o_rdata is valid for o_ld_rd this cycle.
- o_ld_rd  out  5  destination tag of the returning load.
- o_fault  out  1  one-cycle pulse: illegal or out-of-range access, suppressed.
- o_fault_addr  out  32  faulting byte address, held until the next fault.

Behaviour:
- Reset (i_reset==0 at a clock edge):
  - FSM goes to S_IDLE.
  - All outputs are 0, including o_fault_addr.
  - Any pending response is dropped. Reset mid-operation behaves identically.
- FSM states: S_IDLE, S_ISSUE, S_HELD.
- Capture: when i_valid & (i_is_load | i_is_store) & ~i_stall & ~i_flush at edge N, the request is registered and the FSM enters S_ISSUE in cycle N+1.
- In S_ISSUE:
  - o_wren = store & legal; o_rden = load & legal.
  - If i_stall, go to S_HELD. Else capture the next request, or go to S_IDLE if none.
- In S_HELD:
  - Address, masks and data are held; o_wren = o_rden = 0, so a store is never written twice.
  - On ~i_stall, capture the next request or go to S_IDLE.
- Masks, with o = addr[1:0], written as align/misalign:
  - Byte: align = 1<<o, misalign = 0000.
  - Half, o=0: 0011/0000. o=1: 0110/0000. o=2: 1100/0000. o=3: 1000/0001.
  - Word, o=0: 1111/0000. o=1: 1110/0001. o=2: 1100/0011. o=3: 1000/0111.
  - Loads carry the same masks; the memory ignores them on reads.
- Legality. The access is illegal (fault) when any of the following holds:
  - Load with funct3 in {011, 110, 111}.
  - Store with funct3 not in {000, 001, 010}.
  - i_is_load & i_is_store both set.
  - Misalign mask nonzero and ALLOW_MISALIGN==0.
  - Misalign mask nonzero and addr[13:2] == MEM_WORDS-1 (the access would wrap).
- On an illegal access: o_fault pulses in the S_ISSUE cycle, o_wren = o_rden = 0, o_fault_addr is loaded, and no response is generated.
- Load response:
  - A legal load in S_ISSUE sets ld_pending.
  - In the next cycle (N+2) o_ld_valid = 1 and o_ld_rd = the captured rd; the memory's o_rdata is valid in that same cycle.
  - o_ld_valid is high for exactly one cycle per load, even if the stage is stalled.
- Flush:
  - Forces S_IDLE at the edge and deasserts enables from the next cycle.
  - Clears ld_pending, so a load issued in the flush cycle produces no o_ld_valid.
  - Flush has priority over stall and capture.
- Simultaneous capture and response: back-to-back loads give o_ld_valid every cycle, and o_ld_rd tracks each load.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010.
  - A state enum {S_IDLE, S_ISSUE, S_HELD}.
- One combinational sub-module, lsu_mask_gen: (func3, addr[1:0]) -> align mask, misalign mask, size_illegal.
- The FSM, registers and fault/response logic stay in lsu_req_stage.

Test Plan:
- SW addr 0x0000_0102, wdata 0xAABBCCDD -> o_bmask_align 1100, o_bmask_misalign 0011, o_wren=1 for exactly 1 cycle, o_addr 0x0102.
- LH addr 0x0000_0013, rd=7 -> align 1000, misalign 0001; o_rden in cycle N+1; o_ld_valid=1 with o_ld_rd=7 in N+2.
- Store issued, then i_stall held 3 cycles -> o_wren high only in the first cycle; masks and o_addr stable throughout; capture resumes on release.
- SW addr 0x0000_3FFD -> o_fault pulse, o_fault_addr 0x3FFD, o_wren=0. Store with funct3 100 -> o_fault.
- LW rd=3 issued, i_flush in the same cycle -> no o_ld_valid in N+2; the next load (rd=4) returns normally.
- Reset asserted while in S_HELD with a load pending -> all outputs 0 next cycle, no o_ld_valid; normal capture after release.
